obi_multi_fifo_mailbox: RTL

//  Multi-channel OBI-to-OBI mailbox between the serial link (writer port) and the core bus (reader port).
//  NUM_CH independent FIFOs with addressed DATA/STATUS/FLUSH registers per channel.
//  Per-channel fill-level interrupt; blocking or non-blocking read-on-empty mode.

---
 rtl/obi_multi_fifo_mailbox.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/obi_multi_fifo_mailbox.sv
// Multi-channel mailbox: NUM_CH independent FIFOs between a writer OBI port
// (serial link) and a reader OBI port (core bus). Each channel exposes DATA,
// STATUS and FLUSH registers and drives a registered fill-level interrupt.
module obi_multi_fifo_mailbox #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 8,
    parameter int IRQ_LEVEL   = 4,
    parameter int EMPTY_BLOCK = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    writer_req_i,
    output logic                    writer_gnt_o,
    output logic                    writer_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   writer_addr_i,
    input  logic                    writer_we_i,
    input  logic [DATA_WIDTH/8-1:0] writer_be_i,
    input  logic [DATA_WIDTH-1:0]   writer_wdata_i,
    output logic [DATA_WIDTH-1:0]   writer_rdata_o,
    input  logic                    reader_req_i,
    output logic                    reader_gnt_o,
    output logic                    reader_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   reader_addr_i,
    input  logic                    reader_we_i,
    input  logic [DATA_WIDTH/8-1:0] reader_be_i,
    input  logic [DATA_WIDTH-1:0]   reader_wdata_i,
    output logic [DATA_WIDTH-1:0]   reader_rdata_o,
    output logic [NUM_CH-1:0]       irq_o
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_FLUSH  = 2'd2;

    // Per-channel FIFO state
    logic [LVL_W-1:0]      level_q [NUM_CH];
    logic [LVL_W-1:0]      level_d [NUM_CH];
    logic [PTR_W-1:0]      wptr_q  [NUM_CH];
    logic [PTR_W-1:0]      wptr_d  [NUM_CH];
    logic [PTR_W-1:0]      rptr_q  [NUM_CH];
    logic [PTR_W-1:0]      rptr_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] mem_q   [NUM_CH][DEPTH];

    logic [NUM_CH-1:0]     irq_q, irq_d;
    logic [NUM_CH-1:0]     empty_vec, full_vec;
    logic [NUM_CH-1:0]     push_vec, pop_vec, flush_vec;

    // Response registers
    logic                  writer_rvalid_q, writer_rvalid_d;
    logic                  reader_rvalid_q, reader_rvalid_d;
    logic [DATA_WIDTH-1:0] writer_rdata_q, writer_rdata_d;
    logic [DATA_WIDTH-1:0] reader_rdata_q, reader_rdata_d;

    // Address decode
    logic [CH_BITS-1:0]    w_ch, r_ch;
    logic [1:0]            w_reg, r_reg;
    logic                  w_valid, r_valid;
    logic                  w_fire, r_fire;
    logic                  push, pop, w_flush, r_flush;
    logic [DATA_WIDTH-1:0] wdata_masked;

    // Only a few address bits are decoded; the reader never writes data.
    logic unused_inputs;
    assign unused_inputs = ^{writer_addr_i, reader_addr_i, reader_be_i, reader_wdata_i};

    // STATUS layout: [15:0] level, [16] empty, [17] full.
    function automatic logic [DATA_WIDTH-1:0] status_word(input logic [LVL_W-1:0] lvl);
        logic [DATA_WIDTH-1:0] s;
        s            = '0;
        s[LVL_W-1:0] = lvl;
        s[16]        = (lvl == '0);
        s[17]        = (lvl == LVL_W'(DEPTH));
        return s;
    endfunction

    assign w_ch    = (NUM_CH == 1) ? '0 : writer_addr_i[4 +: CH_BITS];
    assign r_ch    = (NUM_CH == 1) ? '0 : reader_addr_i[4 +: CH_BITS];
    assign w_reg   = writer_addr_i[3:2];
    assign r_reg   = reader_addr_i[3:2];
    assign w_valid = (NUM_CH == 1) || (int'(w_ch) < NUM_CH);
    assign r_valid = (NUM_CH == 1) || (int'(r_ch) < NUM_CH);

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_mask
            assign wdata_masked[8*gi +: 8] = writer_be_i[gi] ? writer_wdata_i[8*gi +: 8] : 8'h00;
        end
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign empty_vec[gi] = (level_q[gi] == '0);
            assign full_vec[gi]  = (level_q[gi] == LVL_W'(DEPTH));
            assign push_vec[gi]  = push && (w_ch == CH_BITS'(gi));
            assign pop_vec[gi]   = pop && (r_ch == CH_BITS'(gi));
            assign flush_vec[gi] = (w_flush && (w_ch == CH_BITS'(gi))) ||
                                   (r_flush && (r_ch == CH_BITS'(gi)));
        end
    endgenerate

    // Writer port: grant is only withheld for a DATA write into a full channel.
    always_comb begin
        writer_gnt_o    = !(w_valid && (w_reg == REG_DATA) && writer_we_i && full_vec[w_ch]);
        w_fire          = writer_req_i && writer_gnt_o;
        push            = w_fire && writer_we_i && w_valid && (w_reg == REG_DATA);
        w_flush         = w_fire && writer_we_i && w_valid && (w_reg == REG_FLUSH);
        writer_rvalid_d = w_fire;
        writer_rdata_d  = '0;
        if (w_fire && !writer_we_i && w_valid && (w_reg == REG_STATUS)) begin
            writer_rdata_d = status_word(level_q[w_ch]);
        end
    end

    // Reader port: a DATA read on an empty channel either stalls or returns 0.
    always_comb begin
        reader_gnt_o = 1'b1;
        if (EMPTY_BLOCK != 0) begin
            reader_gnt_o = !(r_valid && (r_reg == REG_DATA) && !reader_we_i && empty_vec[r_ch]);
        end
        r_fire          = reader_req_i && reader_gnt_o;
        pop             = r_fire && !reader_we_i && r_valid && (r_reg == REG_DATA) && !empty_vec[r_ch];
        r_flush         = r_fire && reader_we_i && r_valid && (r_reg == REG_FLUSH);
        reader_rvalid_d = r_fire;
        reader_rdata_d  = '0;
        if (r_fire && !reader_we_i && r_valid && (r_reg == REG_STATUS)) begin
            reader_rdata_d = status_word(level_q[r_ch]);
        end else if (pop) begin
            reader_rdata_d = mem_q[r_ch][rptr_q[r_ch]];
        end
    end

    // Next pointers/levels per channel; a flush overrides any push or pop.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            level_d[c] = level_q[c];
            wptr_d[c]  = wptr_q[c];
            rptr_d[c]  = rptr_q[c];
            if (flush_vec[c]) begin
                level_d[c] = '0;
                wptr_d[c]  = '0;
                rptr_d[c]  = '0;
            end else begin
                if (push_vec[c]) wptr_d[c] = wptr_q[c] + 1'b1;
                if (pop_vec[c])  rptr_d[c] = rptr_q[c] + 1'b1;
                if (push_vec[c] && !pop_vec[c]) level_d[c] = level_q[c] + 1'b1;
                if (pop_vec[c] && !push_vec[c]) level_d[c] = level_q[c] - 1'b1;
            end
            irq_d[c] = (level_d[c] >= LVL_W'(IRQ_LEVEL));
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[w_ch][wptr_q[w_ch]] <= wdata_masked;
        end
    end

    // Control state and registered responses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                level_q[c] <= '0;
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
            end
            irq_q           <= '0;
            writer_rvalid_q <= 1'b0;
            reader_rvalid_q <= 1'b0;
            writer_rdata_q  <= '0;
            reader_rdata_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                level_q[c] <= level_d[c];
                wptr_q[c]  <= wptr_d[c];
                rptr_q[c]  <= rptr_d[c];
            end
            irq_q           <= irq_d;
            writer_rvalid_q <= writer_rvalid_d;
            reader_rvalid_q <= reader_rvalid_d;
            writer_rdata_q  <= writer_rdata_d;
            reader_rdata_q  <= reader_rdata_d;
        end
    end

    assign writer_rvalid_o = writer_rvalid_q;
    assign reader_rvalid_o = reader_rvalid_q;
    assign writer_rdata_o  = writer_rdata_q;
    assign reader_rdata_o  = reader_rdata_q;
    assign irq_o           = irq_q;

endmodule
